// File: rtl/button_debouncer.sv
// Debounces one raw mechanical input using a periodic sample tick. It outputs a clean level plus one-cycle press/release events.
// Optional feature macro: DEBOUNCE_RELEASE_EVT_EN adds the btn_release port and its pulse.
module button_debouncer #(
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter bit          ACTIVE_LOW     = 1'b0,
  localparam int unsigned CNT_W         = $clog2(STABLE_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic             sample_tick,
  input  logic             btn_raw,
  output logic             btn_level,
  output logic             btn_press,
  output logic [CNT_W-1:0] stable_cnt
`ifdef DEBOUNCE_RELEASE_EVT_EN
  ,
  output logic             btn_release
`endif
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HOLD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
  localparam bit               SINGLE   = (STABLE_SAMPLES == 1);

  state_t state_r;
  logic   sync1_r;
  logic   sync2_r;

  // Polarity conversion ahead of a two-flop synchronizer; reset leaves it in the released level.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw ^ ACTIVE_LOW;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM: state, agreement count, committed level and press pulse all move only on a tick.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_r    <= IDLE_LOW;
      stable_cnt <= CNT_ZERO;
      btn_level  <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      if (sample_tick) begin
        case (state_r)
          IDLE_LOW: begin
            if (sync2_r) begin
              if (SINGLE) begin
                state_r    <= HOLD_HIGH;
                stable_cnt <= CNT_ZERO;
                btn_level  <= 1'b1;
                btn_press  <= 1'b1;
              end else begin
                state_r    <= WAIT_HIGH;
                stable_cnt <= CNT_ONE;
              end
            end else begin
              stable_cnt <= CNT_ZERO;
            end
          end
          WAIT_HIGH: begin
            if (sync2_r) begin
              if (stable_cnt == CNT_LAST) begin
                state_r    <= HOLD_HIGH;
                stable_cnt <= CNT_ZERO;
                btn_level  <= 1'b1;
                btn_press  <= 1'b1;
              end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
              end
            end else begin
              // Bounce aborts the candidate silently.
              state_r    <= IDLE_LOW;
              stable_cnt <= CNT_ZERO;
            end
          end
          HOLD_HIGH: begin
            if (!sync2_r) begin
              if (SINGLE) begin
                state_r    <= IDLE_LOW;
                stable_cnt <= CNT_ZERO;
                btn_level  <= 1'b0;
              end else begin
                state_r    <= WAIT_LOW;
                stable_cnt <= CNT_ONE;
              end
            end else begin
              stable_cnt <= CNT_ZERO;
            end
          end
          WAIT_LOW: begin
            if (!sync2_r) begin
              if (stable_cnt == CNT_LAST) begin
                state_r    <= IDLE_LOW;
                stable_cnt <= CNT_ZERO;
                btn_level  <= 1'b0;
              end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
              end
            end else begin
              state_r    <= HOLD_HIGH;
              stable_cnt <= CNT_ZERO;
            end
          end
          default: begin
            state_r    <= IDLE_LOW;
            stable_cnt <= CNT_ZERO;
            btn_level  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_RELEASE_EVT_EN
  logic fall_commit_s;

  // A falling commit happens on exactly the tick that moves the FSM back to IDLE_LOW.
  assign fall_commit_s = sample_tick & ~sync2_r &
                         ((state_r == WAIT_LOW) ? (stable_cnt == CNT_LAST)
                                                : ((state_r == HOLD_HIGH) & SINGLE));

  // Release pulse register, aligned with the falling edge of btn_level.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      btn_release <= 1'b0;
    end else begin
      btn_release <= fall_commit_s;
    end
  end
`else
  // Without the release event a falling commit only clears btn_level.
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: an abstract per-cycle model and hand-computed checkpoints.
// Two instances are exercised: (STABLE_SAMPLES=4, ACTIVE_LOW=0) and (STABLE_SAMPLES=1, ACTIVE_LOW=1).
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_a_p = 1'b0;
  logic       sample_tick = 1'b0;
  logic       btn_raw_a = 1'b0;
  logic       btn_raw_b = 1'b1;
  logic       level_a, press_a, level_b, press_b;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
`ifdef DEBOUNCE_RELEASE_EVT_EN
  logic       rel_a, rel_b;
`endif

  int errors = 0;
  int total  = 0;

  button_debouncer #(.STABLE_SAMPLES(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_a_p(rst_a_p), .sample_tick(sample_tick), .btn_raw(btn_raw_a),
    .btn_level(level_a), .btn_press(press_a), .stable_cnt(cnt_a)
`ifdef DEBOUNCE_RELEASE_EVT_EN
    , .btn_release(rel_a)
`endif
  );

  button_debouncer #(.STABLE_SAMPLES(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_a_p(rst_a_p), .sample_tick(sample_tick), .btn_raw(btn_raw_b),
    .btn_level(level_b), .btn_press(press_b), .stable_cnt(cnt_b)
`ifdef DEBOUNCE_RELEASE_EVT_EN
    , .btn_release(rel_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed level plus a run length of consecutive disagreeing tick samples.
  int ss[2] = '{4, 1};
  int al[2] = '{0, 1};
  int lvl[2], run[2], prs[2], rls[2], d1[2], d2[2];
  int smp, raw_i;

  initial begin
    for (int i = 0; i < 2; i++) begin
      lvl[i] = 0; run[i] = 0; prs[i] = 0; rls[i] = 0; d1[i] = 0; d2[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      raw_i = (i == 0) ? int'(btn_raw_a) : int'(btn_raw_b);
      if (rst_a_p) begin
        lvl[i] = 0; run[i] = 0; prs[i] = 0; rls[i] = 0; d1[i] = 0; d2[i] = 0;
      end else begin
        smp = d2[i];
        d2[i] = d1[i];
        d1[i] = raw_i ^ al[i];
        prs[i] = 0;
        rls[i] = 0;
        if (sample_tick) begin
          if (smp != lvl[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == ss[i]) begin
              lvl[i] = smp;
              run[i] = 0;
              if (smp == 1) prs[i] = 1;
              else rls[i] = 1;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
    end
    #1;
    check("cmp_level_a", level_a, lvl[0]);
    check("cmp_press_a", press_a, prs[0]);
    check("cmp_cnt_a",   cnt_a,   run[0]);
    check("cmp_level_b", level_b, lvl[1]);
    check("cmp_press_b", press_b, prs[1]);
    check("cmp_cnt_b",   cnt_b,   run[1]);
`ifdef DEBOUNCE_RELEASE_EVT_EN
    check("cmp_rel_a",   rel_a,   rls[0]);
    check("cmp_rel_b",   rel_b,   rls[1]);
    check("excl_a",      press_a & rel_a, 0);
`endif
  end

  // One tick period of 10 clk; the tick lands on the last cycle, long after the synchronizer settles.
  task automatic period(input logic a, input logic b);
    btn_raw_a = a;
    btn_raw_b = b;
    sample_tick = 1'b0;
    repeat (9) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  initial begin
    logic [6:0] bounce;
    bounce = 7'b1111011;

    btn_raw_a = 1'b1;
    #1 rst_a_p = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_level", level_a, 0);
      check("rst_press", press_a, 0);
      check("rst_cnt",   cnt_a,   0);
    end
    rst_a_p = 1'b0;
    btn_raw_a = 1'b0;
    period(1'b0, 1'b1);
    period(1'b0, 1'b1);
    check("idle_level", level_a, 0);

    // Clean press: count 1,2,3 then commit with a single press pulse.
    for (int k = 1; k <= 3; k++) begin
      period(1'b1, 1'b1);
      check("press_cnt", cnt_a, k);
      check("press_wait_level", level_a, 0);
    end
    period(1'b1, 1'b1);
    check("press_level", level_a, 1);
    check("press_pulse", press_a, 1);
    check("press_cnt0",  cnt_a,   0);
    @(negedge clk);
    check("press_pulse_end", press_a, 0);
    check("press_hold", level_a, 1);

    // Release after four low samples.
    for (int k = 1; k <= 3; k++) period(1'b0, 1'b1);
    check("rel_wait_level", level_a, 1);
    check("rel_wait_cnt", cnt_a, 3);
    period(1'b0, 1'b1);
    check("rel_level", level_a, 0);
`ifdef DEBOUNCE_RELEASE_EVT_EN
    check("rel_pulse", rel_a, 1);
`endif

    // Bounce: samples 1,1,0,1,1,1,1.
    for (int k = 0; k < 7; k++) begin
      period(bounce[k], 1'b1);
      if (k == 2) begin
        check("bounce_abort_cnt", cnt_a, 0);
        check("bounce_abort_level", level_a, 0);
      end
      if (k == 5) check("bounce_cnt3", cnt_a, 3);
    end
    check("bounce_level", level_a, 1);
    check("bounce_press", press_a, 1);
    for (int k = 0; k < 4; k++) period(1'b0, 1'b1);
    check("bounce_release_level", level_a, 0);

    // Active-low single-sample instance.
    period(1'b0, 1'b0);
    check("al_level", level_b, 1);
    check("al_press", press_b, 1);
    check("al_cnt",   cnt_b,   0);
    period(1'b0, 1'b1);
    check("al_release_level", level_b, 0);

    // Reset in the middle of WAIT_HIGH discards the candidate.
    period(1'b1, 1'b1);
    period(1'b1, 1'b1);
    check("mid_cnt2", cnt_a, 2);
    rst_a_p = 1'b1;
    #1;
    check("mid_rst_cnt",   cnt_a,   0);
    check("mid_rst_level", level_a, 0);
    repeat (2) @(negedge clk);
    rst_a_p = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      period(1'b1, 1'b1);
      check("requal_cnt", cnt_a, k);
      check("requal_no_press", press_a, 0);
    end
    period(1'b1, 1'b1);
    check("requal_level", level_a, 1);
    check("requal_press", press_a, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
